// File: rtl/acc_cpu_pkg.sv
// acc_cpu_pkg: opcodes, sequencer state encoding and default widths shared
// by the 8-bit accumulator CPU sequencer, its ALU and its memory interface.
package acc_cpu_pkg;

    localparam int DEF_AW = 6;
    localparam int DEF_DW = 8;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_JMP = 2'b10;
    localparam logic [1:0] OP_INC = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC
    } seq_state_t;

endpackage

// File: rtl/acc_cpu_seq_if.sv
// acc_cpu_seq_if: program/data memory bus of the accumulator CPU.
// The sequencer is the only master; the memory answers combinationally.
interface acc_cpu_seq_if
    import acc_cpu_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
);

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;

    modport master (
        output mem_addr,
        input  mem_data
    );

    modport slave (
        input  mem_addr,
        output mem_data
    );

endinterface

// File: rtl/acc_cpu_alu.sv
// acc_cpu_alu: combinational datapath for ADD, AND and INC.
// Carry is only meaningful for ADD and INC; the sequencer decides whether
// to keep it.
module acc_cpu_alu
    import acc_cpu_pkg::*;
#(
    parameter int DW = DEF_DW
) (
    input  logic [1:0]    op,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] result,
    output logic          carry
);

    logic [DW:0] sum;

    // One wide adder result per operation; AND and JMP never produce a carry
    always_comb begin
        sum    = '0;
        result = a;
        carry  = 1'b0;
        case (op)
            OP_ADD: begin
                sum    = {1'b0, a} + {1'b0, b};
                result = sum[DW-1:0];
                carry  = sum[DW];
            end
            OP_INC: begin
                sum    = {1'b0, a} + {{DW{1'b0}}, 1'b1};
                result = sum[DW-1:0];
                carry  = sum[DW];
            end
            OP_AND: begin
                result = a & b;
            end
            default: begin
                result = a;
            end
        endcase
    end

endmodule

// File: rtl/acc_cpu_seq.sv
// acc_cpu_seq: multicycle fetch/decode/execute sequencer of the 8-bit
// accumulator CPU. Drives the registered memory address, holds PC, IR, AC
// and carry, and retires one instruction per FETCH/DECODE[/EXEC] pass.
// Build option: define ACC_SINGLE_STEP_EN to retire exactly one instruction
// per step pulse instead of free-running on run.
module acc_cpu_seq
    import acc_cpu_pkg::*;
#(
    parameter int            AW       = DEF_AW,
    parameter int            DW       = DEF_DW,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run,
    input  logic                 step,
    acc_cpu_seq_if.master        mem,
    output logic [DW-1:0]        ac,
    output logic [AW-1:0]        pc,
    output logic                 carry,
    output logic                 instr_done,
    output logic                 busy
);

    seq_state_t    state;
    seq_state_t    state_nxt;
    logic [AW-1:0] mem_addr_q;
    logic [AW-1:0] addr_nxt;
    logic [AW-1:0] pc_nxt;
    logic [AW-1:0] pc_ret;
    logic [DW-1:0] ir;
    logic [DW-1:0] ir_nxt;
    logic [DW-1:0] ac_nxt;
    logic          carry_nxt;
    logic          done_nxt;
    logic          retire;
    logic          start;
    logic          keep_running;
    logic [1:0]    dec_op;
    logic [AW-1:0] dec_operand;
    logic [1:0]    alu_op;
    logic [DW-1:0] alu_result;
    logic          alu_carry;

    assign mem.mem_addr = mem_addr_q;
    assign busy         = (state != ST_IDLE);
    assign dec_op       = mem.mem_data[DW-1:DW-2];
    assign dec_operand  = mem.mem_data[AW-1:0];

`ifdef ACC_SINGLE_STEP_EN
    logic unused_bits;
    assign start        = step;
    assign keep_running = 1'b0;
    assign unused_bits  = ^{run, ir[DW-3:0]};
`else
    logic unused_bits;
    assign start        = run;
    assign keep_running = run;
    assign unused_bits  = ^{step, ir[DW-3:0]};
`endif

    // INC executes straight from the word being decoded; ADD/AND use the held IR
    assign alu_op = (state == ST_DECODE) ? dec_op : ir[DW-1:DW-2];

    acc_cpu_alu #(
        .DW(DW)
    ) u_alu (
        .op     (alu_op),
        .a      (ac),
        .b      (mem.mem_data),
        .result (alu_result),
        .carry  (alu_carry)
    );

    // Register the FSM state and architectural state; reset discards any instruction in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            pc         <= RESET_PC;
            mem_addr_q <= RESET_PC;
            ac         <= '0;
            ir         <= '0;
            carry      <= 1'b0;
            instr_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            mem_addr_q <= addr_nxt;
            ac         <= ac_nxt;
            ir         <= ir_nxt;
            carry      <= carry_nxt;
            instr_done <= done_nxt;
        end
    end

    // Next-state and next-register logic; retirement folds in the fetch-or-idle choice
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        addr_nxt  = mem_addr_q;
        ac_nxt    = ac;
        ir_nxt    = ir;
        carry_nxt = carry;
        done_nxt  = 1'b0;
        retire    = 1'b0;
        pc_ret    = pc;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    addr_nxt  = pc;
                    state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_nxt = ST_DECODE;
            end
            ST_DECODE: begin
                ir_nxt = mem.mem_data;
                case (dec_op)
                    OP_JMP: begin
                        pc_ret = dec_operand;
                        retire = 1'b1;
                    end
                    OP_INC: begin
                        ac_nxt    = alu_result;
                        carry_nxt = alu_carry;
                        pc_ret    = pc + 1'b1;
                        retire    = 1'b1;
                    end
                    default: begin
                        addr_nxt  = dec_operand;
                        pc_nxt    = pc + 1'b1;
                        state_nxt = ST_EXEC;
                    end
                endcase
            end
            ST_EXEC: begin
                ac_nxt = alu_result;
                if (ir[DW-1:DW-2] == OP_ADD) begin
                    carry_nxt = alu_carry;
                end
                pc_ret = pc;
                retire = 1'b1;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        if (retire) begin
            pc_nxt   = pc_ret;
            done_nxt = 1'b1;
            if (keep_running) begin
                addr_nxt  = pc_ret;
                state_nxt = ST_FETCH;
            end else begin
                state_nxt = ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_acc_cpu_seq.sv
// tb_acc_cpu_seq: self-checking bench for acc_cpu_seq. An instruction-level
// model predicts the architectural state after each retirement into a queue;
// a monitor pops and compares on every instr_done pulse. Directed checks
// cover reset, latency, carry, PC wrap, run drop and reset mid-instruction.
// Define ACC_SINGLE_STEP_EN to exercise the single-step build instead.
`timescale 1ns/1ps
module tb_acc_cpu_seq;

    typedef struct packed {
        logic [7:0] ac;
        logic [5:0] pc;
        logic       carry;
    } archState_t;

    logic       clk;
    logic       rstN;
    logic       run;
    logic       step;
    logic [7:0] ac;
    logic [5:0] pc;
    logic       carry;
    logic       instrDone;
    logic       busy;
    logic [7:0] mem [64];

    archState_t expQ[$];
    int         assertCount = 0;
    int         failCount   = 0;
    int         retireCount = 0;
    logic [5:0] modelPc;
    logic [7:0] modelAc;
    logic       modelCarry;

    acc_cpu_seq_if #(.AW(6), .DW(8)) bus ();

    assign bus.mem_data = mem[bus.mem_addr];

    acc_cpu_seq #(
        .AW       (6),
        .DW       (8),
        .RESET_PC (6'd0)
    ) dut (
        .clk        (clk),
        .rst_n      (rstN),
        .run        (run),
        .step       (step),
        .mem        (bus),
        .ac         (ac),
        .pc         (pc),
        .carry      (carry),
        .instr_done (instrDone),
        .busy       (busy)
    );

    // Free-running 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the bench can never hang
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: time limit reached before the end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic newRstN, input logic newRun, input logic newStep);
        rstN = newRstN;
        run  = newRun;
        step = newStep;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic waitRetire(input int limit, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (instrDone !== 1'b1 && cycles < limit);
        if (instrDone !== 1'b1) checkOutput("retireTimeout", 32'd0, 32'd1);
    endtask

    task automatic resetDut();
        applyStimulus(1'b0, 1'b0, 1'b0);
        waitCycles(2);
    endtask

    task automatic clearMem();
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    endtask

    task automatic loadImage1();
        clearMem();
        mem[0]  = 8'h3F;
        mem[1]  = 8'h7E;
        mem[2]  = 8'hC0;
        mem[3]  = 8'h82;
        mem[62] = 8'h20;
        mem[63] = 8'h3F;
    endtask

    task automatic loadImage2();
        clearMem();
        mem[0]  = 8'h3C;
        mem[1]  = 8'hC0;
        mem[2]  = 8'h7D;
        mem[3]  = 8'hBF;
        mem[60] = 8'hFF;
        mem[61] = 8'h0F;
        mem[63] = 8'hC0;
    endtask

    task automatic modelReset();
        modelPc    = 6'd0;
        modelAc    = 8'h00;
        modelCarry = 1'b0;
        expQ.delete();
    endtask

    // Instruction-level reference: executes n instructions and queues the result of each
    task automatic predict(input int n);
        logic [7:0] w;
        logic [8:0] s;
        for (int i = 0; i < n; i++) begin
            w = mem[modelPc];
            case (w[7:6])
                2'b00: begin
                    s          = {1'b0, modelAc} + {1'b0, mem[w[5:0]]};
                    modelAc    = s[7:0];
                    modelCarry = s[8];
                    modelPc    = modelPc + 6'd1;
                end
                2'b01: begin
                    modelAc = modelAc & mem[w[5:0]];
                    modelPc = modelPc + 6'd1;
                end
                2'b10: begin
                    modelPc = w[5:0];
                end
                default: begin
                    s          = {1'b0, modelAc} + 9'd1;
                    modelAc    = s[7:0];
                    modelCarry = s[8];
                    modelPc    = modelPc + 6'd1;
                end
            endcase
            expQ.push_back({modelAc, modelPc, modelCarry});
        end
    endtask

    // Scoreboard monitor: every retirement must match the next predicted state
    always @(negedge clk) begin
        archState_t e;
        if (instrDone === 1'b1) begin
            retireCount++;
            if (expQ.size() == 0) begin
                checkOutput("unexpectedRetire", 32'd1, 32'd0);
            end else begin
                e = expQ.pop_front();
                checkOutput("sbAc", ac, e.ac);
                checkOutput("sbPc", pc, e.pc);
                checkOutput("sbCarry", carry, e.carry);
            end
        end
    end

    // Main stimulus sequence
    initial begin
        int cyc;
        applyStimulus(1'b0, 1'b0, 1'b0);
        clearMem();
        modelReset();
        waitCycles(2);

`ifdef ACC_SINGLE_STEP_EN
        loadImage1();
        modelReset();
        predict(3);
        retireCount = 0;
        applyStimulus(1'b1, 1'b1, 1'b0);
        waitCycles(3);
        checkOutput("ssRunIgnored", busy, 1'b0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b1);
            waitCycles(1);
            checkOutput("ssBusyAfterStep", busy, 1'b1);
            waitCycles(1);
            applyStimulus(1'b1, 1'b1, 1'b0);
            waitRetire(10, cyc);
            waitCycles(3);
            checkOutput("ssIdleAfterRetire", busy, 1'b0);
        end
        checkOutput("ssFinalAc", ac, 8'h21);
        checkOutput("ssRetireCount", retireCount, 32'd3);
`else
        // Free run from reset through the AC wrap
        loadImage1();
        modelReset();
        predict(450);
        checkOutput("rstPc", pc, 6'd0);
        checkOutput("rstAc", ac, 8'h00);
        checkOutput("rstCarry", carry, 1'b0);
        checkOutput("rstBusy", busy, 1'b0);
        checkOutput("rstDone", instrDone, 1'b0);
        checkOutput("rstAddr", bus.mem_addr, 6'd0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        waitRetire(10, cyc);
        checkOutput("firstRetireCycle", cyc, 32'd4);
        checkOutput("addAc", ac, 8'h3F);
        checkOutput("addCarry", carry, 1'b0);
        checkOutput("addPc", pc, 6'd1);
        waitRetire(10, cyc);
        checkOutput("andLatency", cyc, 32'd3);
        checkOutput("andAc", ac, 8'h20);
        waitRetire(10, cyc);
        checkOutput("incLatency", cyc, 32'd2);
        checkOutput("incAc", ac, 8'h21);
        waitRetire(10, cyc);
        checkOutput("jmpLatency", cyc, 32'd2);
        checkOutput("jmpPc", pc, 6'd2);
        for (int i = 0; i < 446; i++) begin
            waitRetire(10, cyc);
            checkOutput("loopLatency", cyc, 32'd2);
        end
        checkOutput("wrapAc", ac, 8'h00);
        checkOutput("wrapCarry", carry, 1'b1);
        checkOutput("wrapPc", pc, 6'd2);
        predict(1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitRetire(10, cyc);
        checkOutput("idleAfterDrop", busy, 1'b0);

        // AND keeps carry, INC at 63 wraps the PC
        resetDut();
        loadImage2();
        modelReset();
        predict(8);
        applyStimulus(1'b1, 1'b1, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            waitRetire(10, cyc);
            if (i == 3) begin
                checkOutput("andKeepsCarry", carry, 1'b1);
                checkOutput("andZeroAc", ac, 8'h00);
            end
            if (i == 5) begin
                checkOutput("pcWrap", pc, 6'd0);
                checkOutput("pcWrapAc", ac, 8'h01);
            end
            if (i == 7) applyStimulus(1'b1, 1'b0, 1'b0);
        end
        checkOutput("img2Idle", busy, 1'b0);

        // Drop run during EXEC, then resume from the saved PC
        resetDut();
        loadImage1();
        modelReset();
        predict(3);
        applyStimulus(1'b1, 1'b1, 1'b0);
        waitCycles(3);
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitRetire(5, cyc);
        checkOutput("dropRetireCycle", cyc, 32'd1);
        checkOutput("dropBusy", busy, 1'b0);
        waitCycles(3);
        checkOutput("holdBusy", busy, 1'b0);
        checkOutput("holdPc", pc, 6'd1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        waitCycles(1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitCycles(2);
        checkOutput("stepIgnored", busy, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        waitRetire(10, cyc);
        checkOutput("resumeLatency", cyc, 32'd4);
        checkOutput("resumeAc", ac, 8'h20);
        checkOutput("resumePc", pc, 6'd2);
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitRetire(10, cyc);
        checkOutput("resumeIdle", busy, 1'b0);

        // Reset asserted during EXEC of AND
        resetDut();
        loadImage1();
        modelReset();
        predict(1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        waitRetire(10, cyc);
        waitCycles(2);
        checkOutput("execAddr", bus.mem_addr, 6'd62);
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitCycles(1);
        checkOutput("midRstPc", pc, 6'd0);
        checkOutput("midRstAc", ac, 8'h00);
        checkOutput("midRstCarry", carry, 1'b0);
        checkOutput("midRstDone", instrDone, 1'b0);
        checkOutput("midRstBusy", busy, 1'b0);
        checkOutput("midRstAddr", bus.mem_addr, 6'd0);
        waitCycles(2);
`endif

        checkOutput("queueEmpty", expQ.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
